zymason_disp_loader: RTL and testbench

ZYMASON_DISP_LOADER -- requirements
Module: zymason_disp_loader

---
 rtl/zymason_pkg.sv | 23 ++
 rtl/zymason_nibble_sel.sv | 34 +++
 rtl/zymason_disp_loader.sv | 155 +++++++++++++++
 tb/tb_zymason_disp_loader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/zymason_pkg.sv
// Shared types and constants for the zymason display loader.
// Build option: ZYMASON_LOADER_DISP_RST_EN adds the display-reset step.
package zymason_pkg;

    localparam int SEG_W          = 7;
    localparam int NUM_DIGITS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        ARM,
        HI,
        LO,
        EX1,
        EX2
    } loader_state_t;

    // Digit index width; a single-digit display still needs one index bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zymason_nibble_sel.sv
// Combinational nibble picker: selects digit k from the latch and returns
// its high 3 bits (zero-extended) or its low 4 bits depending on sel.
module zymason_nibble_sel
    import zymason_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int K_W        = idx_w(NUM_DIGITS)
) (
    input  logic [SEG_W*NUM_DIGITS-1:0] digit_latch,
    input  logic [K_W-1:0]              k,
    input  logic                        sel,
    output logic [3:0]                  pin
);

    logic [SEG_W-1:0] digit_arr [NUM_DIGITS];
    logic [SEG_W-1:0] seg;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
            assign digit_arr[gi] = digit_latch[gi*SEG_W +: SEG_W];
        end
    endgenerate

    // Out-of-range indices (non power-of-two digit counts) read as blank.
    always_comb begin
        seg = '0;
        pin = '0;
        if (32'(k) < 32'(NUM_DIGITS)) begin
            seg = digit_arr[k];
        end
        pin = sel ? {1'b0, seg[6:4]} : seg[3:0];
    end

endmodule

// File: rtl/zymason_disp_loader.sv
// Loads NUM_DIGITS 7-segment patterns into a nibble-wide display.
// Build option: ZYMASON_LOADER_DISP_RST_EN inserts a display-reset cycle.
module zymason_disp_loader
    import zymason_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [SEG_W*NUM_DIGITS-1:0] digits,
    output logic                        busy,
    output logic                        done,
    output logic                        disp_rst,
    output logic                        disp_rw,
    output logic                        disp_sel,
    output logic [3:0]                  disp_pin
);

    localparam int             K_W    = idx_w(NUM_DIGITS);
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_DIGITS - 1);

    loader_state_t               state_reg;
    logic [K_W-1:0]              k_reg;
    logic [SEG_W*NUM_DIGITS-1:0] latch_reg;
    logic                        busy_reg;
    logic                        done_reg;
    logic                        rw_reg;
    logic                        sel_reg;
    logic [3:0]                  pin_reg;

    // Outputs are registered, so the picker looks at the digit and half
    // that the state being entered will present.
    logic [K_W-1:0] nib_k;
    logic           nib_sel;
    logic [3:0]     nib_pin;

    assign nib_k   = (state_reg == LO) ? k_reg + K_W'(1) : k_reg;
    assign nib_sel = (state_reg != HI);

    zymason_nibble_sel #(
        .NUM_DIGITS (NUM_DIGITS),
        .K_W        (K_W)
    ) u_nibble_sel (
        .digit_latch (latch_reg),
        .k           (nib_k),
        .sel         (nib_sel),
        .pin         (nib_pin)
    );

`ifdef ZYMASON_LOADER_DISP_RST_EN
    logic disp_rst_reg;
    assign disp_rst = disp_rst_reg;
`else
    assign disp_rst = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            k_reg        <= '0;
            latch_reg    <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            rw_reg       <= 1'b0;
            sel_reg      <= 1'b0;
            pin_reg      <= 4'h0;
`ifdef ZYMASON_LOADER_DISP_RST_EN
            disp_rst_reg <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        latch_reg <= digits;
                        k_reg     <= '0;
                        busy_reg  <= 1'b1;
                        sel_reg   <= 1'b0;
                        pin_reg   <= 4'h0;
`ifdef ZYMASON_LOADER_DISP_RST_EN
                        state_reg    <= RST;
                        disp_rst_reg <= 1'b1;
                        rw_reg       <= 1'b0;
`else
                        state_reg <= ARM;
                        rw_reg    <= 1'b1;
`endif
                    end
                end
`ifdef ZYMASON_LOADER_DISP_RST_EN
                RST: begin
                    state_reg    <= ARM;
                    disp_rst_reg <= 1'b0;
                    rw_reg       <= 1'b1;
                    sel_reg      <= 1'b0;
                    pin_reg      <= 4'h0;
                end
`endif
                ARM: begin
                    state_reg <= HI;
                    rw_reg    <= 1'b1;
                    sel_reg   <= 1'b1;
                    pin_reg   <= nib_pin;
                end
                HI: begin
                    state_reg <= LO;
                    sel_reg   <= 1'b0;
                    pin_reg   <= nib_pin;
                end
                LO: begin
                    if (k_reg == K_LAST) begin
                        state_reg <= EX1;
                        rw_reg    <= 1'b0;
                        sel_reg   <= 1'b1;
                        pin_reg   <= 4'h0;
                    end else begin
                        k_reg     <= k_reg + K_W'(1);
                        state_reg <= HI;
                        sel_reg   <= 1'b1;
                        pin_reg   <= nib_pin;
                    end
                end
                EX1: begin
                    state_reg <= EX2;
                    rw_reg    <= 1'b0;
                    sel_reg   <= 1'b0;
                    pin_reg   <= 4'h0;
                    done_reg  <= 1'b1;
                end
                EX2: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    rw_reg    <= 1'b0;
                    sel_reg   <= 1'b0;
                    pin_reg   <= 4'h0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    rw_reg    <= 1'b0;
                    sel_reg   <= 1'b0;
                    pin_reg   <= 4'h0;
                end
            endcase
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign disp_rw  = rw_reg;
    assign disp_sel = sel_reg;
    assign disp_pin = pin_reg;

endmodule

// File: tb/tb_zymason_disp_loader.sv
// Directed bench for zymason_disp_loader with a behavioural nibble display.
// Honours ZYMASON_LOADER_DISP_RST_EN for the expected transfer length.
module tb_zymason_disp_loader;

`ifdef ZYMASON_LOADER_DISP_RST_EN
    localparam int CYC = 12;
    localparam int P0  = 0;
`else
    localparam int CYC = 11;
    localparam int P0  = 1;
`endif

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [27:0] digits  = '0;
    logic        busy, done, disp_rst, disp_rw, disp_sel;
    logic [3:0]  disp_pin;

    int tests_run    = 0;
    int tests_failed = 0;

    zymason_disp_loader #(.NUM_DIGITS(4)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (start),
        .digits   (digits),
        .busy     (busy),
        .done     (done),
        .disp_rst (disp_rst),
        .disp_rw  (disp_rw),
        .disp_sel (disp_sel),
        .disp_pin (disp_pin)
    );

    always #5 clock = ~clock;

    // Behavioural display: a high nibble followed by a low nibble in write
    // mode stores one digit and advances the wrapping digit pointer.
    logic [6:0] dmem [4];
    logic [1:0] dptr;
    logic [2:0] dhi;
    logic       dhi_valid;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) dmem[i] <= '0;
            dptr      <= '0;
            dhi       <= '0;
            dhi_valid <= 1'b0;
        end else if (disp_rst) begin
            dptr      <= '0;
            dhi_valid <= 1'b0;
        end else if (disp_rw) begin
            if (disp_sel) begin
                dhi       <= disp_pin[2:0];
                dhi_valid <= 1'b1;
            end else if (dhi_valid) begin
                dmem[dptr] <= {dhi, disp_pin};
                dptr       <= dptr + 2'd1;
                dhi_valid  <= 1'b0;
            end
        end else begin
            dhi_valid <= 1'b0;
        end
    end

    typedef struct {
        string       name;
        logic [27:0] digits;
        logic [47:0] seq;   // 12 pin nibbles, RST slot first
    } vec_t;

    vec_t vecs [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] exp_ctl(input int p, input logic [47:0] seq);
        logic rst_e, rw_e, sel_e, done_e;
        logic [3:0] pin_e;
        rst_e  = (p == 0);
        rw_e   = (p >= 1) && (p <= 9);
        sel_e  = ((p >= 2) && (p <= 9) && (p % 2 == 0)) || (p == 10);
        done_e = (p == 11);
        pin_e  = seq[47 - 4*p -: 4];
        return {rst_e, rw_e, sel_e, pin_e, 1'b1, done_e};
    endfunction

    function automatic logic [8:0] obs_ctl();
        return {disp_rst, disp_rw, disp_sel, disp_pin, busy, done};
    endfunction

    // Caller must be positioned just after a falling edge.
    task automatic run_xfer(input string name, input logic [27:0] d, input logic [47:0] seq,
                            input int restart_c, input int zero_c, input int abort_c);
        int done_cnt;
        int bad_cycles;
        done_cnt   = 0;
        bad_cycles = tests_failed;
        digits = d;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c <= CYC; c++) begin
            if (c > 1) @(negedge clock);
            check($sformatf("%s cyc%0d", name, c), 32'(obs_ctl()), 32'(exp_ctl(c - 1 + P0, seq)));
            if (done) done_cnt++;
            start = (c == restart_c);
            if (c == zero_c) digits = '0;
            if (c == abort_c) begin
                reset_n = 1'b0;
                #1;
                check($sformatf("%s async_reset_outputs", name), 32'(obs_ctl()), 32'd0);
                @(negedge clock);
                check($sformatf("%s held_reset_outputs", name), 32'(obs_ctl()), 32'd0);
                reset_n = 1'b1;
                $display("[TB] xfer %-10s digits=%h aborted at cycle %0d", name, d, c);
                return;
            end
        end
        @(negedge clock);
        check($sformatf("%s idle_after", name), 32'(obs_ctl()), 32'd0);
        check($sformatf("%s done_pulses", name), 32'(done_cnt), 32'd1);
        check($sformatf("%s display_mem", name),
              32'({dmem[3], dmem[2], dmem[1], dmem[0]}), 32'(d));
        $display("[TB] xfer %-10s digits=%h cycles=%0d errors=%0d", name, d, CYC,
                 tests_failed - bad_cycles);
    endtask

    initial begin
        vecs[0] = '{"req_vec", {7'h4F, 7'h5B, 7'h06, 7'h3F}, 48'h003F065B4F00};
        vecs[1] = '{"mixed",   {7'h7F, 7'h00, 7'h12, 7'h5A}, 48'h005A12007F00};
        vecs[2] = '{"sparse",  {7'h01, 7'h70, 7'h2C, 7'h0D}, 48'h000D2C700100};

        #1;
        check("reset_outputs", 32'(obs_ctl()), 32'd0);
        start = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("reset_ignores_start", 32'(obs_ctl()), 32'd0);
        start   = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("idle_no_start", 32'(obs_ctl()), 32'd0);

        for (int i = 0; i < 3; i++) begin
            run_xfer(vecs[i].name, vecs[i].digits, vecs[i].seq, 0, 0, 0);
        end

        run_xfer("restart5", vecs[0].digits, vecs[0].seq, 5, 0, 0);
        run_xfer("zero_dig", vecs[2].digits, vecs[2].seq, 0, 1, 0);
        run_xfer("abort_lo2", vecs[0].digits, vecs[0].seq, 0, 0, 8 - P0);
        run_xfer("post_rst", vecs[1].digits, vecs[1].seq, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
